parking_sensor_filter: RTL and testbench
========================================

// Module: parking_sensor_filter
// PURPOSE
// - Two-channel input conditioner directly upstream of vehicle_counter.
// - Takes the raw, asynchronous beam sensors S1 (outer) and S2 (inner) from the Pmod pins.
// - Synchronizes each sensor and debounces it, then drives clean levels into vehicle_counter S1/S2.
// - Also provides 1-cycle edge strobes and a saturating glitch counter for diagnostics.
// PARAMETERS
// - SYNC_STAGES      2          flip-flops in each synchronizer chain (>=2)
// - DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles needed to accept a level (>=2); 10 ms at 100 MHz
// - CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived, do not override)
// PORTS
// - clk         in   1      100 MHz system clock
// - rst_n       in   1      async active-low reset; the top level drives it with ~btnC
// - s1_raw      in   1      raw outer sensor, asynchronous to clk
// - s2_raw      in   1      raw inner sensor, asynchronous to clk
// - s1_clean    out  1      debounced S1 level, to vehicle_counter.S1
// - s2_clean    out  1      debounced S2 level, to vehicle_counter.S2
// - s1_rise     out  1      1-cycle strobe in the cycle s1_clean goes 0->1
// - s2_rise     out  1      1-cycle strobe in the cycle s2_clean goes 0->1
// - glitch_cnt  out  8      count of rejected pulses, both channels combined, saturates at 255
// BEHAVIOUR
// Reset
// - rst_n=0 clears all of the following at once, without waiting for clk:
//   sync flops, counters and glitch_cnt to 0; all outputs to 0; both FSMs to ST_LO.
// - Reset asserted mid-debounce drops the pending change.
// - After release, a raw input held at 1 must pass the full latency before its clean output rises.
// Synchronizer
// - s*_raw passes through SYNC_STAGES flops; the last flop is s*_sync.
// FSM (one per channel, registered, sampled on the posedge of clk)
// - States: ST_LO, ST_WAIT_HI, ST_HI, ST_WAIT_LO.
// - ST_LO:      sync=1 -> ST_WAIT_HI, cnt=1. Otherwise stay.
// - ST_WAIT_HI: sync=0 -> ST_LO, cnt=0, glitch event.
//               sync=1 and cnt==DEBOUNCE_CYCLES-1 -> ST_HI, clean<=1, rise<=1, cnt=0.
//               Otherwise cnt++.
// - ST_HI:      sync=0 -> ST_WAIT_LO, cnt=1. Otherwise stay.
// - ST_WAIT_LO: sync=1 -> ST_HI, cnt=0, glitch event.
//               sync=0 and cnt==DEBOUNCE_CYCLES-1 -> ST_LO, clean<=0, cnt=0.
//               Otherwise cnt++.
// Outputs and timing
// - s*_clean is 1 exactly in ST_HI and ST_WAIT_LO.
// - s*_rise is high for exactly one cycle and never in two consecutive cycles.
// - Latency: clean changes on posedge #(SYNC_STAGES+DEBOUNCE_CYCLES) after the raw level settles.
//   With the defaults this is 2+1_000_000 cycles.
// - A pulse shorter than DEBOUNCE_CYCLES synced cycles never reaches clean and counts as one glitch event.
// Glitch counter
// - Adds 1 per channel glitch event, 2 if both channels abort in the same cycle.
// - Saturates at 255; it never wraps.
// Channel independence
// - The two channels are fully independent; simultaneous edges are filtered in parallel.
// - No ordering is imposed here; entry/exit decoding belongs to vehicle_counter.
// TESTING
// All benches run with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 10 ns clock.
// 1. Reset: rst_n=0 mid-cycle with s1_raw=1.
//    -> all outputs 0 asynchronously; after release, s1_clean=1 on posedge 6 and s1_rise high that cycle only.
// 2. Clean step: s2_raw 0->1 held.
//    -> s2_clean rises on posedge 6 after the change, s2_rise 1 cycle; 1->0 falls 6 edges later with no strobe.
// 3. Glitch: s1_raw high for 3 cycles, then low.
//    -> s1_clean stays 0, glitch_cnt 0->1; same for a 3-cycle low dip while high: clean stays 1, glitch_cnt=2.
// 4. Simultaneous: both raws glitch on the same cycles -> glitch_cnt +2 in one cycle.
//    Both raws step together -> s1_clean and s2_clean rise on the same edge.
// 5. Saturation: 300 short glitches on s1_raw -> glitch_cnt holds at 255.
// 6. Chain with vehicle_counter: bounced entry on s1_raw then s2_raw, with 3 chatter pulses per edge.
//    -> exactly one s1_rise and one s2_rise; vehicle_counter count +1.

Source files
------------

// File: rtl/parking_sensor_filter.sv
// Two-channel beam-sensor conditioner placed in front of vehicle_counter.
// Each raw sensor is synchronized and then debounced by a small FSM. A level is
// accepted only after DEBOUNCE_CYCLES consecutive synced samples at that level.
// The block also produces 1-cycle rising-edge strobes and a saturating count of
// rejected pulses from both channels.
module parking_sensor_filter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s1_raw,
    input  logic       s2_raw,
    output logic       s1_clean,
    output logic       s2_clean,
    output logic       s1_rise,
    output logic       s2_rise,
    output logic [7:0] glitch_cnt
);
    // Derived from DEBOUNCE_CYCLES and not meant to be overridden.
    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic [1:0] {
        StLo,
        StWaitHi,
        StHi,
        StWaitLo
    } state_e;

    logic [1:0] raw;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] glitch;

    // Index 0 is the outer sensor S1 and index 1 is the inner sensor S2.
    assign raw = {s2_raw, s1_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_bit;
        state_e                 state_q;
        state_e                 state_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   rise_q;
        logic                   rise_d;
        logic                   glitch_ev;

        // Synchronizer chain; the raw pin is asynchronous to clk.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
            end
        end

        assign sync_bit = sync_q[SYNC_STAGES-1];

        // Debounce state, stability counter and rise strobe registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StLo;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
            end
        end

        // Next-state logic. A pending change that sees the old level again is
        // dropped and reported as one glitch event.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            rise_d    = 1'b0;
            glitch_ev = 1'b0;
            case (state_q)
                StLo: begin
                    if (sync_bit) begin
                        state_d = StWaitHi;
                        cnt_d   = CntOne;
                    end
                end
                StWaitHi: begin
                    if (!sync_bit) begin
                        state_d   = StLo;
                        cnt_d     = '0;
                        glitch_ev = 1'b1;
                    end else if (cnt_q == CntLast) begin
                        state_d = StHi;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StHi: begin
                    if (!sync_bit) begin
                        state_d = StWaitLo;
                        cnt_d   = CntOne;
                    end
                end
                StWaitLo: begin
                    if (sync_bit) begin
                        state_d   = StHi;
                        cnt_d     = '0;
                        glitch_ev = 1'b1;
                    end else if (cnt_q == CntLast) begin
                        state_d = StLo;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StLo;
                    cnt_d   = '0;
                end
            endcase
        end

        // Clean level stays high while a pending fall is still being qualified.
        assign clean[ch]  = (state_q == StHi) || (state_q == StWaitLo);
        assign rise[ch]   = rise_q;
        assign glitch[ch] = glitch_ev;
    end

    logic [7:0] glitch_cnt_q;
    logic [7:0] glitch_cnt_d;
    logic [1:0] glitch_sum;
    logic [8:0] glitch_add;

    // Saturating add of 0, 1 or 2 glitch events per cycle.
    always_comb begin
        glitch_sum   = {1'b0, glitch[0]} + {1'b0, glitch[1]};
        glitch_add   = {1'b0, glitch_cnt_q} + {7'b0, glitch_sum};
        glitch_cnt_d = glitch_add[8] ? 8'hff : glitch_add[7:0];
    end

    // Glitch counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign s1_clean   = clean[0];
    assign s2_clean   = clean[1];
    assign s1_rise    = rise[0];
    assign s2_rise    = rise[1];
    assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_parking_sensor_filter.sv
// Bench for parking_sensor_filter with DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
// It uses a hand-derived vector table, directed reset, chatter and saturation
// sequences, and a random phase checked against a run-length reference model.
module tb_parking_sensor_filter;
    localparam int unsigned SYNC_STAGES     = 2;
    localparam int unsigned DEBOUNCE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       s1_raw = 1'b0;
    logic       s2_raw = 1'b0;
    logic       s1_clean;
    logic       s2_clean;
    logic       s1_rise;
    logic       s2_rise;
    logic [7:0] glitch_cnt;

    parking_sensor_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s1_raw    (s1_raw),
        .s2_raw    (s2_raw),
        .s1_clean  (s1_clean),
        .s2_clean  (s2_clean),
        .s1_rise   (s1_rise),
        .s2_rise   (s2_rise),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int rise1_cnt = 0;
    int rise2_cnt = 0;

    // Reference model. The FSM sees each raw sample SYNC_STAGES edges late.
    // A level is accepted after DEBOUNCE_CYCLES consecutive samples that differ
    // from the current clean level. A shorter run is one glitch.
    bit m_hist[2][SYNC_STAGES];
    bit m_clean[2];
    bit m_rise[2];
    int m_run[2];
    int m_glitch;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < SYNC_STAGES; k++) m_hist[c][k] = 1'b0;
            m_clean[c] = 1'b0;
            m_rise[c]  = 1'b0;
            m_run[c]   = 0;
        end
        m_glitch = 0;
    endfunction

    function automatic void model_step(bit r1, bit r2);
        bit raw[2];
        bit seen;
        int add = 0;
        raw[0] = r1;
        raw[1] = r2;
        for (int c = 0; c < 2; c++) begin
            seen = m_hist[c][SYNC_STAGES-1];
            for (int k = SYNC_STAGES - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = raw[c];
            m_rise[c] = 1'b0;
            if (seen != m_clean[c]) begin
                m_run[c]++;
                if (m_run[c] == DEBOUNCE_CYCLES) begin
                    m_clean[c] = seen;
                    m_rise[c]  = seen;
                    m_run[c]   = 0;
                end
            end else if (m_run[c] > 0) begin
                add++;
                m_run[c] = 0;
            end
        end
        m_glitch = (m_glitch + add > 255) ? 255 : m_glitch + add;
    endfunction

    function automatic logic [11:0] model_outs();
        return {m_clean[0], m_clean[1], m_rise[0], m_rise[1], 8'(m_glitch)};
    endfunction

    function automatic logic [11:0] dut_outs();
        return {s1_clean, s2_clean, s1_rise, s2_rise, glitch_cnt};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: the model samples raw at the edge, then outputs settle.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(s1_raw, s2_raw);
        #1;
        if (s1_rise) rise1_cnt++;
        if (s2_rise) rise2_cnt++;
    endtask

    task automatic tick_chk(input string name);
        tick();
        check(name, dut_outs(), model_outs());
    endtask

    task automatic do_reset();
        s1_raw = 1'b0;
        s2_raw = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rise1_cnt = 0;
        rise2_cnt = 0;
    endtask

    // Short pulses: two high samples, then two low samples.
    task automatic pulses(input int n, input bit both);
        for (int p = 0; p < n; p++) begin
            s1_raw = 1'b1;
            s2_raw = both;
            tick_chk("pulse_hi");
            tick_chk("pulse_hi");
            s1_raw = 1'b0;
            s2_raw = 1'b0;
            tick_chk("pulse_lo");
            tick_chk("pulse_lo");
        end
        tick_chk("pulse_idle");
        tick_chk("pulse_idle");
    endtask

    typedef struct {
        logic       s1;
        logic       s2;
        logic       c1;
        logic       c2;
        logic       r1;
        logic       r2;
        logic [7:0] g;
    } vec_t;

    vec_t vecs[$];

    function automatic void rep(int n, logic s1, logic s2, logic c1, logic c2,
                                logic r1, logic r2, logic [7:0] g);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.c1 = c1; v.c2 = c2; v.r1 = r1; v.r2 = r2; v.g = g;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        int hold1;
        int hold2;

        // Table rows: raw inputs before an edge, then expected outputs after it.
        rep(5, 0, 1, 0, 0, 0, 0, 0);  // S2 step in
        rep(1, 0, 1, 0, 1, 0, 1, 0);  // accepted on the 6th edge with a strobe
        rep(2, 0, 1, 0, 1, 0, 0, 0);
        rep(5, 0, 0, 0, 1, 0, 0, 0);  // S2 step out
        rep(3, 0, 0, 0, 0, 0, 0, 0);  // falls on the 6th edge, no strobe
        rep(3, 1, 0, 0, 0, 0, 0, 0);  // 3-cycle S1 pulse
        rep(2, 0, 0, 0, 0, 0, 0, 0);
        rep(2, 0, 0, 0, 0, 0, 0, 1);  // rejected as one glitch
        rep(5, 1, 0, 0, 0, 0, 0, 1);  // S1 step in
        rep(1, 1, 0, 1, 0, 1, 0, 1);
        rep(2, 1, 0, 1, 0, 0, 0, 1);
        rep(3, 0, 0, 1, 0, 0, 0, 1);  // 3-cycle low dip while high
        rep(2, 1, 0, 1, 0, 0, 0, 1);
        rep(2, 1, 0, 1, 0, 0, 0, 2);
        rep(5, 0, 0, 1, 0, 0, 0, 2);  // S1 step out
        rep(2, 0, 0, 0, 0, 0, 0, 2);
        rep(2, 1, 1, 0, 0, 0, 0, 2);  // simultaneous 2-cycle glitches
        rep(2, 0, 0, 0, 0, 0, 0, 2);
        rep(2, 0, 0, 0, 0, 0, 0, 4);  // +2 in a single cycle
        rep(5, 1, 1, 0, 0, 0, 0, 4);  // both step together
        rep(1, 1, 1, 1, 1, 1, 1, 4);
        rep(1, 1, 1, 1, 1, 0, 0, 4);
        rep(5, 0, 0, 1, 1, 0, 0, 4);
        rep(2, 0, 0, 0, 0, 0, 0, 4);

        model_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_state", dut_outs(), 12'h000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            s1_raw = vecs[i].s1;
            s2_raw = vecs[i].s2;
            tick();
            check($sformatf("vec%0d", i), dut_outs(),
                  {vecs[i].c1, vecs[i].c2, vecs[i].r1, vecs[i].r2, vecs[i].g});
        end
        check("post_table_model", dut_outs(), model_outs());

        // Mid-cycle asynchronous reset with S1 high and a nonzero glitch count.
        s1_raw = 1'b1;
        repeat (8) tick_chk("pre_reset");
        check("pre_reset_clean", {11'b0, s1_clean}, 12'h001);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_outs(), 12'h000);
        @(posedge clk);
        #1;
        check("reset_hold", dut_outs(), 12'h000);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("rel_clean_e%0d", e), {11'b0, s1_clean}, {11'b0, e >= 6});
            check($sformatf("rel_rise_e%0d", e), {11'b0, s1_rise}, {11'b0, e == 6});
        end

        // Reset during a pending rise drops it.
        do_reset();
        s1_raw = 1'b1;
        repeat (4) tick_chk("pend");
        s1_raw = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) tick_chk("pend_dropped");
        check("pend_clean", {11'b0, s1_clean}, 12'h000);

        // Bounced entry: chatter on S1 then S2, then bounced exit.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            s1_raw = 1'b1; tick_chk("ch_s1_in");
            s1_raw = 1'b0; tick_chk("ch_s1_in");
        end
        s1_raw = 1'b1;
        repeat (8) tick_chk("ch_s1_hold");
        for (int k = 0; k < 3; k++) begin
            s2_raw = 1'b1; tick_chk("ch_s2_in");
            s2_raw = 1'b0; tick_chk("ch_s2_in");
        end
        s2_raw = 1'b1;
        repeat (8) tick_chk("ch_s2_hold");
        check("entry_state", {10'b0, s1_clean, s2_clean}, 12'h003);
        check("entry_glitches", {4'b0, glitch_cnt}, 12'd6);
        for (int k = 0; k < 3; k++) begin
            s1_raw = 1'b0; tick_chk("ch_s1_out");
            s1_raw = 1'b1; tick_chk("ch_s1_out");
        end
        s1_raw = 1'b0;
        repeat (8) tick_chk("ch_s1_low");
        for (int k = 0; k < 3; k++) begin
            s2_raw = 1'b0; tick_chk("ch_s2_out");
            s2_raw = 1'b1; tick_chk("ch_s2_out");
        end
        s2_raw = 1'b0;
        repeat (8) tick_chk("ch_s2_low");
        check("chatter_s1_rises", 12'(rise1_cnt), 12'd1);
        check("chatter_s2_rises", 12'(rise2_cnt), 12'd1);
        check("exit_state", {10'b0, s1_clean, s2_clean}, 12'h000);
        check("exit_glitches", {4'b0, glitch_cnt}, 12'd12);

        // Saturation with single-channel glitches.
        do_reset();
        pulses(100, 1'b0);
        check("sat_100", {4'b0, glitch_cnt}, 12'd100);
        pulses(200, 1'b0);
        check("sat_300", {4'b0, glitch_cnt}, 12'd255);

        // Saturation when a double event lands on 254.
        do_reset();
        pulses(127, 1'b1);
        check("dual_254", {4'b0, glitch_cnt}, 12'd254);
        pulses(1, 1'b1);
        check("dual_sat", {4'b0, glitch_cnt}, 12'd255);

        // Random hold lengths that straddle the debounce threshold.
        do_reset();
        hold1 = 0;
        hold2 = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold1 == 0) begin
                s1_raw = ~s1_raw;
                hold1  = int'($urandom_range(1, 7));
            end
            if (hold2 == 0) begin
                s2_raw = ($urandom_range(0, 3) == 0) ? s1_raw : ~s2_raw;
                hold2  = int'($urandom_range(1, 7));
            end
            hold1--;
            hold2--;
            tick_chk("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
